// File: rtl/edge_pkg.sv
// Shared constants and FSM state type for the edge-map packing stage.
package edge_pkg;

   localparam int IMG_W        = 32;
   localparam int IMG_H        = 32;
   localparam int FRAME_PIX    = IMG_W * IMG_H;
   localparam int PIX_PER_WORD = 8;
   localparam int WORD_CNT     = FRAME_PIX / PIX_PER_WORD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PACK = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/edge_bit_packer.sv
// Accumulates binary pixels into a byte; word_out already contains the bit
// being inserted this cycle so the byte is complete on its last pixel.
module edge_bit_packer (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       bit_in,
   input  logic [2:0] bit_idx,
   output logic [7:0] word_out
);

   logic [7:0] acc;

   always_comb begin
      word_out          = acc;
      word_out[bit_idx] = bit_in;
   end

   // Clear after the last bit so a new word never carries old pixels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= 8'h00;
      end else if (en) begin
         acc <= (bit_idx == 3'd7) ? 8'h00 : word_out;
      end
   end

endmodule

// File: rtl/edge_pack_wr.sv
// Binarizes a raster edge-magnitude stream, packs 8 pixels per byte and writes
// the frame to result memory. EDGE_PACK_CNT_EN adds the per-frame 1-pixel count.
module edge_pack_wr #(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [7:0]        edge_in,
   input  logic [7:0]        thresh,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              done,
   output logic [10:0]       edge_cnt
);

   import edge_pkg::*;

   localparam int               PIX_W    = ADDR_W + 3;
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_W * IMG_H - 1);

   state_t           state;
   logic [PIX_W-1:0] pix_cnt;
   logic [7:0]       thr_q;

   logic             frame_start;
   logic [7:0]       thr_eff;
   logic             pix_bit;
   logic             word_end;
   logic             frame_end;
   logic [7:0]       packed_word;

   // Pixel 0 is accepted outside PACK and must use the live threshold.
   assign frame_start = (state != PACK);
   assign thr_eff     = frame_start ? thresh : thr_q;
   assign pix_bit     = (edge_in >= thr_eff);
   assign word_end    = valid && (pix_cnt[2:0] == 3'd7);
   assign frame_end   = valid && (pix_cnt == LAST_PIX);

   edge_bit_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .en       (valid),
      .bit_in   (pix_bit),
      .bit_idx  (pix_cnt[2:0]),
      .word_out (packed_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pix_cnt <= '0;
         thr_q   <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (valid) begin
                  thr_q   <= thresh;
                  pix_cnt <= PIX_W'(1);
                  state   <= PACK;
               end
            end
            PACK: begin
               if (valid) begin
                  if (pix_cnt == LAST_PIX) begin
                     pix_cnt <= '0;
                     state   <= DONE;
                  end else begin
                     pix_cnt <= pix_cnt + PIX_W'(1);
                  end
               end
            end
            DONE: begin
               if (valid) begin
                  thr_q   <= thresh;
                  pix_cnt <= PIX_W'(1);
                  state   <= PACK;
               end else begin
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output stage: one write per completed word, done on the last word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'h00;
         done      <= 1'b0;
      end else begin
         mem_we <= word_end;
         done   <= frame_end;
         if (word_end) begin
            mem_addr  <= pix_cnt[PIX_W-1:3];
            mem_wdata <= packed_word;
         end
      end
   end

`ifdef EDGE_PACK_CNT_EN
   logic [10:0] cnt_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_acc  <= 11'd0;
         edge_cnt <= 11'd0;
      end else if (valid) begin
         cnt_acc <= (frame_start ? 11'd0 : cnt_acc) + 11'(pix_bit);
         if (frame_end) begin
            edge_cnt <= cnt_acc + 11'(pix_bit);
         end
      end
   end
`else
   assign edge_cnt = 11'd0;
`endif

endmodule

// File: tb/tb_edge_pack_wr.sv
// Scoreboard bench for edge_pack_wr: randomized frames, reference model in plain arithmetic.
module tb_edge_pack_wr;

   logic       clk;
   logic       rst;
   logic       valid;
   logic [7:0] edge_in;
   logic [7:0] thresh;
   logic       mem_we;
   logic [6:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       done;
   logic [10:0] edge_cnt;

   edge_pack_wr #(.IMG_W(32), .IMG_H(32), .ADDR_W(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .edge_in   (edge_in),
      .thresh    (thresh),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .done      (done),
      .edge_cnt  (edge_cnt)
   );

   typedef struct {
      int         addr;
      logic [7:0] data;
      bit         is_done;
      int         cnt;
      longint     cyc;
   } exp_t;

   exp_t   q[$];
   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   bit     cnt_en;

   // reference model state
   int         m_pix = 0;
   int         m_thr = 0;
   int         m_cnt = 0;
   logic [7:0] m_word = 8'h00;

   // last observed write, used for hold checks
   int last_addr = 0;
   int last_data = 0;
   int hold_cnt  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic model_accept(input int d, input int t);
      int b;
      exp_t e;
      if (m_pix == 0) begin
         m_thr = t;
         m_cnt = 0;
      end
      b = (d >= m_thr) ? 1 : 0;
      m_word[m_pix % 8] = b[0];
      m_cnt += b;
      if (m_pix % 8 == 7) begin
         e.addr    = m_pix / 8;
         e.data    = m_word;
         e.is_done = (m_pix == 1023);
         e.cnt     = cnt_en ? m_cnt : 0;
         e.cyc     = cyc + 1;
         q.push_back(e);
      end
      m_pix = (m_pix + 1) % 1024;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic [7:0] t);
      @(posedge clk);
      #1;
      valid   = v;
      edge_in = d;
      thresh  = t;
      if (v) model_accept(int'(d), int'(t));
   endtask

   // pattern: 0 alternating 0/255, 1 random, 2 constant 254, 3 constant 100
   // gap: 0 none, 1 every other cycle, 2 random
   task automatic send_frame(input int pattern, input int thr_a, input int thr_b,
                             input int switch_after, input int gap, input int npix);
      logic [7:0] d;
      logic [7:0] t;
      for (int i = 0; i < npix; i++) begin
         case (pattern)
            0:       d = (i % 2 == 1) ? 8'd255 : 8'd0;
            1:       d = 8'($urandom_range(0, 255));
            2:       d = 8'd254;
            default: d = 8'd100;
         endcase
         t = (i > switch_after) ? 8'(thr_b) : 8'(thr_a);
         if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0))
            drive(1'b0, 8'($urandom_range(0, 255)), t);
         drive(1'b1, d, t);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, thresh);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (mem_we) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0d data %0h with empty scoreboard", mem_addr, mem_wdata);
            end else begin
               e = q.pop_front();
               chk("mem_addr", 32'(mem_addr), 32'(e.addr));
               chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
               chk("done_with_write", 32'(done), 32'(e.is_done));
               chk("write_cycle", 32'(cyc), 32'(e.cyc));
               last_addr = e.addr;
               last_data = int'(e.data);
               if (e.is_done) hold_cnt = e.cnt;
            end
         end else begin
            chk("done_idle", 32'(done), 32'd0);
            chk("addr_hold", 32'(mem_addr), 32'(last_addr));
            chk("wdata_hold", 32'(mem_wdata), 32'(last_data));
         end
         chk("edge_cnt", 32'(edge_cnt), 32'(hold_cnt));
      end
   end

   task automatic check_reset_outputs();
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
   endtask

   initial begin
`ifdef EDGE_PACK_CNT_EN
      cnt_en = 1'b1;
`else
      cnt_en = 1'b0;
`endif
      rst     = 1'b1;
      valid   = 1'b0;
      edge_in = 8'h00;
      thresh  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;
      idle(2);

      send_frame(0, 128, 128, 2000, 0, 1024);   // alternating -> 8'hAA
      idle(3);
      send_frame(1, 0, 0, 2000, 0, 1024);       // thresh 0 -> all ones
      idle(2);
      send_frame(2, 255, 255, 2000, 0, 1024);   // 254 < 255 -> all zeros
      idle(2);
      send_frame(0, 128, 128, 2000, 1, 1024);   // gaps every other cycle
      idle(2);
      send_frame(3, 10, 200, 5, 0, 1024);       // threshold frozen at pixel 0
      idle(2);
      send_frame(1, $urandom_range(0, 255), 0, 2000, 0, 1024);  // back-to-back pair
      send_frame(1, $urandom_range(0, 255), 0, 2000, 0, 1024);
      idle(2);

      send_frame(1, 100, 100, 2000, 0, 301);    // reset after pixel 300
      @(posedge clk);
      #1;
      rst   = 1'b1;
      valid = 1'b0;
      #1;
      check_reset_outputs();
      q.delete();
      m_pix     = 0;
      m_word    = 8'h00;
      last_addr = 0;
      last_data = 0;
      hold_cnt  = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_frame(1, $urandom_range(0, 255), 0, 2000, 2, 1024);
      send_frame(1, $urandom_range(0, 255), 0, 2000, 2, 1024);
      idle(4);

      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
